// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: FSM states,
// 4-bit opcode codes, ALU operation codes and the decoded instruction class.
package ctrl_pkg;

  // State encoding kept as plain constants so the register stays a bare vector
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC_R = 3'd2;
  localparam logic [2:0] ST_EXEC_M = 3'd3;
  localparam logic [2:0] ST_EXEC_B = 3'd4;
  localparam logic [2:0] ST_MEM    = 3'd5;
  localparam logic [2:0] ST_WB     = 3'd6;
  localparam logic [2:0] ST_JUMP   = 3'd7;

  localparam logic [3:0] OPC_AND = 4'h0;
  localparam logic [3:0] OPC_OR  = 4'h1;
  localparam logic [3:0] OPC_ADD = 4'h2;
  localparam logic [3:0] OPC_SUB = 4'h6;
  localparam logic [3:0] OPC_SLT = 4'h7;
  localparam logic [3:0] OPC_LW  = 4'h8;
  localparam logic [3:0] OPC_SW  = 4'hA;
  localparam logic [3:0] OPC_BNE = 4'hE;
  localparam logic [3:0] OPC_J   = 4'hF;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LW,
    CLS_SW,
    CLS_BNE,
    CLS_J,
    CLS_ILL
  } op_class_e;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode classifier: instruction class plus R-type ALU operation.
// J (0x0F) is legal only when CTRL_JUMP_EN is defined.
module ctrl_opdecode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_e           op_class,
  output logic [2:0]          r_alu_op
);

  logic       upper_zero;
  logic [3:0] code;

  // Legal codes are zero-extended 4-bit values; any set upper bit is illegal
  if (OPCODE_W > 4) begin : g_wide
    assign upper_zero = ~|opcode[OPCODE_W-1:4];
  end else begin : g_narrow
    assign upper_zero = 1'b1;
  end
  assign code = opcode[3:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    op_class = CLS_ILL;
    r_alu_op = ALU_ADD;
    if (upper_zero) begin
      case (code)
        OPC_AND: begin op_class = CLS_R; r_alu_op = ALU_AND; end
        OPC_OR:  begin op_class = CLS_R; r_alu_op = ALU_OR;  end
        OPC_ADD: begin op_class = CLS_R; r_alu_op = ALU_ADD; end
        OPC_SUB: begin op_class = CLS_R; r_alu_op = ALU_SUB; end
        OPC_SLT: begin op_class = CLS_R; r_alu_op = ALU_SLT; end
        OPC_LW:  op_class = CLS_LW;
        OPC_SW:  op_class = CLS_SW;
        OPC_BNE: op_class = CLS_BNE;
`ifdef CTRL_JUMP_EN
        OPC_J:   op_class = CLS_J;
`endif
        default: op_class = CLS_ILL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// mem_ready handshake and bounded memory-wait timeout. Optional J support: CTRL_JUMP_EN.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int ALU_OP_W     = 3,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                retire,
  output logic                illegal,
  output logic                mem_err
);

  localparam int                WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic [OPCODE_W-1:0] dec_opcode;
  op_class_e           dec_class;
  logic [2:0]          dec_alu_op;
  logic                mem_wait;
  logic                timeout;

  // DECODE classifies the live opcode; every other state works from the latched one
  assign dec_opcode = (state_q == ST_DECODE) ? opcode : op_q;
  assign op_d       = (state_q == ST_DECODE) ? opcode : op_q;

  ctrl_opdecode #(
    .OPCODE_W (OPCODE_W)
  ) u_opdecode (
    .opcode   (dec_opcode),
    .op_class (dec_class),
    .r_alu_op (dec_alu_op)
  );

  assign mem_wait = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  assign timeout  = mem_wait && (wait_q == WAIT_LAST);
  assign wait_d   = (mem_wait && !timeout) ? wait_q + 1'b1 : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (timeout) state_d = ST_FETCH;
      end
      ST_DECODE: begin
        case (dec_class)
          CLS_R:           state_d = ST_EXEC_R;
          CLS_LW, CLS_SW:  state_d = ST_EXEC_M;
          CLS_BNE:         state_d = ST_EXEC_B;
`ifdef CTRL_JUMP_EN
          CLS_J:           state_d = ST_JUMP;
`endif
          default:         state_d = ST_FETCH;
        endcase
      end
      ST_EXEC_R: state_d = ST_WB;
      ST_EXEC_M: state_d = ST_MEM;
      ST_EXEC_B: state_d = ST_FETCH;
      ST_MEM: begin
        if (mem_ready)    state_d = (dec_class == CLS_LW) ? ST_WB : ST_FETCH;
        else if (timeout) state_d = ST_FETCH;
      end
      ST_WB:     state_d = ST_FETCH;
`ifdef CTRL_JUMP_EN
      ST_JUMP:   state_d = ST_FETCH;
`endif
      default:   state_d = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs are forced low while rst_n is asserted, so no strobe leaks during reset.
  // pc_src[1] is only ever set in JUMP, so without CTRL_JUMP_EN it is constant 0.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          alu_op   = ALU_OP_W'(ALU_ADD);
          ir_write = mem_ready;
          pc_write = mem_ready;
          mem_err  = timeout;
        end
        ST_DECODE: illegal = (dec_class == CLS_ILL);
        ST_EXEC_R: alu_op = ALU_OP_W'(dec_alu_op);
        ST_EXEC_M: begin
          alu_src = 1'b1;
          alu_op  = ALU_OP_W'(ALU_ADD);
        end
        ST_EXEC_B: begin
          alu_op   = ALU_OP_W'(ALU_SUB);
          pc_write = !zero;
          pc_src   = zero ? 2'd0 : 2'd1;
          retire   = 1'b1;
        end
        ST_MEM: begin
          mem_read  = (dec_class == CLS_LW);
          mem_write = (dec_class != CLS_LW);
          retire    = mem_ready && (dec_class != CLS_LW);
          mem_err   = timeout;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          retire     = 1'b1;
          reg_dst    = (dec_class == CLS_R);
          mem_to_reg = (dec_class == CLS_LW);
        end
`ifdef CTRL_JUMP_EN
        ST_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          retire   = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues per-cycle expected
// strobes, a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       retire;
    logic       illegal;
    logic       mem_err;
  } out_t;

  typedef struct {
    out_t  exp;
    string tag;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  out_t       got;

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  localparam logic [5:0] JUNK = 6'h3F;

  multicycle_control #(
    .OPCODE_W     (6),
    .ALU_OP_W     (3),
    .MEM_WAIT_MAX (15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ir_write   (got.ir_write),
    .pc_write   (got.pc_write),
    .pc_src     (got.pc_src),
    .reg_dst    (got.reg_dst),
    .reg_write  (got.reg_write),
    .alu_src    (got.alu_src),
    .alu_op     (got.alu_op),
    .mem_read   (got.mem_read),
    .mem_write  (got.mem_write),
    .mem_to_reg (got.mem_to_reg),
    .retire     (got.retire),
    .illegal    (got.illegal),
    .mem_err    (got.mem_err)
  );

  always #5 clk = ~clk;

  // Hand-derived strobe sets for each controller phase
  function automatic out_t o_fetch(input logic rdy, input logic err);
    out_t o = '0;
    o.mem_read = 1'b1; o.alu_op = 3'd2;
    o.ir_write = rdy;  o.pc_write = rdy; o.mem_err = err;
    return o;
  endfunction

  function automatic out_t o_decode(input logic ill);
    out_t o = '0;
    o.illegal = ill;
    return o;
  endfunction

  function automatic out_t o_exec_r(input logic [2:0] op);
    out_t o = '0;
    o.alu_op = op;
    return o;
  endfunction

  function automatic out_t o_exec_m();
    out_t o = '0;
    o.alu_src = 1'b1; o.alu_op = 3'd2;
    return o;
  endfunction

  function automatic out_t o_exec_b(input logic z);
    out_t o = '0;
    o.alu_op = 3'd3; o.retire = 1'b1;
    o.pc_write = !z; o.pc_src = z ? 2'd0 : 2'd1;
    return o;
  endfunction

  function automatic out_t o_mem(input logic lw, input logic rdy, input logic err);
    out_t o = '0;
    o.mem_read = lw; o.mem_write = !lw;
    o.retire = rdy && !lw; o.mem_err = err;
    return o;
  endfunction

  function automatic out_t o_wb(input logic lw);
    out_t o = '0;
    o.reg_write = 1'b1; o.retire = 1'b1;
    o.reg_dst = !lw; o.mem_to_reg = lw;
    return o;
  endfunction

  function automatic out_t o_jump();
    out_t o = '0;
    o.pc_write = 1'b1; o.pc_src = 2'd2; o.retire = 1'b1;
    return o;
  endfunction

  task automatic step(input logic [5:0] opc, input logic z, input logic rdy,
                      input out_t exp, input string tag);
    item_t it;
    opcode    = opc;
    zero      = z;
    mem_ready = rdy;
    it.exp    = exp;
    it.tag    = tag;
    exp_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      item_t it;
      it = exp_q.pop_front();
      n_cmp++;
      if (got !== it.exp) begin
        n_err++;
        $display("FAIL %s: got=%b required=%b (t=%0t)", it.tag, got, it.exp, $time);
      end
    end
  end

  initial begin
    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step(JUNK, 0, 1, '0, "reset_idle0");
    step(JUNK, 0, 1, '0, "reset_idle1");
    rst_n = 1'b1;

    // ADD, zero-wait memory, junk opcode outside DECODE
    step(JUNK, 0, 1, o_fetch(1, 0), "add_fetch");
    step(6'h02, 0, 1, o_decode(0), "add_decode");
    step(JUNK, 0, 1, o_exec_r(3'd2), "add_exec");
    step(JUNK, 0, 1, o_wb(0), "add_wb");

    // SLT and OR select their own ALU codes
    step(JUNK, 0, 1, o_fetch(1, 0), "slt_fetch");
    step(6'h07, 0, 1, o_decode(0), "slt_decode");
    step(JUNK, 0, 1, o_exec_r(3'd4), "slt_exec");
    step(JUNK, 0, 1, o_wb(0), "slt_wb");
    step(JUNK, 0, 1, o_fetch(1, 0), "or_fetch");
    step(6'h01, 0, 1, o_decode(0), "or_decode");
    step(JUNK, 0, 1, o_exec_r(3'd1), "or_exec");
    step(JUNK, 0, 1, o_wb(0), "or_wb");

    // LW with three MEM wait cycles
    step(JUNK, 0, 1, o_fetch(1, 0), "lw_fetch");
    step(6'h08, 0, 1, o_decode(0), "lw_decode");
    step(JUNK, 0, 1, o_exec_m(), "lw_exec");
    for (int i = 0; i < 3; i++) step(JUNK, 0, 0, o_mem(1, 0, 0), "lw_mem_wait");
    step(JUNK, 0, 1, o_mem(1, 1, 0), "lw_mem_done");
    step(JUNK, 0, 1, o_wb(1), "lw_wb");

    // BNE taken and not taken
    step(JUNK, 1, 1, o_fetch(1, 0), "bne0_fetch");
    step(6'h0E, 1, 1, o_decode(0), "bne0_decode");
    step(JUNK, 0, 1, o_exec_b(0), "bne0_exec");
    step(JUNK, 0, 1, o_fetch(1, 0), "bne1_fetch");
    step(6'h0E, 0, 1, o_decode(0), "bne1_decode");
    step(JUNK, 1, 1, o_exec_b(1), "bne1_exec");

    // SW: mem_ready arriving in the would-be timeout cycle completes normally
    step(JUNK, 0, 1, o_fetch(1, 0), "swok_fetch");
    step(6'h0A, 0, 1, o_decode(0), "swok_decode");
    step(JUNK, 0, 1, o_exec_m(), "swok_exec");
    for (int i = 0; i < 14; i++) step(JUNK, 0, 0, o_mem(0, 0, 0), "swok_wait");
    step(JUNK, 0, 1, o_mem(0, 1, 0), "swok_done");

    // SW with mem_ready stuck low: timeout on the 15th wait, no retire
    step(JUNK, 0, 1, o_fetch(1, 0), "swto_fetch");
    step(6'h0A, 0, 1, o_decode(0), "swto_decode");
    step(JUNK, 0, 1, o_exec_m(), "swto_exec");
    for (int i = 0; i < 14; i++) step(JUNK, 0, 0, o_mem(0, 0, 0), "swto_wait");
    step(JUNK, 0, 0, o_mem(0, 0, 1), "swto_err");

    // FETCH timeout retries; the wait counter restarts afterwards
    for (int i = 0; i < 14; i++) step(JUNK, 0, 0, o_fetch(0, 0), "fto_wait");
    step(JUNK, 0, 0, o_fetch(0, 1), "fto_err");
    step(JUNK, 0, 0, o_fetch(0, 0), "fto_restart");
    step(JUNK, 0, 1, o_fetch(1, 0), "fto_fetch");

    // Upper opcode bits set make an otherwise legal low nibble illegal
    step(6'h12, 0, 1, o_decode(1), "ill12_decode");
    step(JUNK, 0, 1, o_fetch(1, 0), "ill12_next_fetch");

    // Opcode 0x0F
`ifdef CTRL_JUMP_EN
    step(6'h0F, 0, 1, o_decode(0), "j_decode");
    step(JUNK, 0, 1, o_jump(), "j_exec");
`else
    step(6'h0F, 0, 1, o_decode(1), "j_illegal");
`endif
    step(JUNK, 0, 1, o_fetch(1, 0), "post_j_fetch");

    // Reset asserted mid-cycle during MEM of SW, with mem_ready high
    step(6'h0A, 0, 1, o_decode(0), "swrst_decode");
    step(JUNK, 0, 1, o_exec_m(), "swrst_exec");
    step(JUNK, 0, 0, o_mem(0, 0, 0), "swrst_mem");
    rst_n = 1'b0;
    step(JUNK, 0, 1, '0, "swrst_in_reset");
    rst_n = 1'b1;
    step(JUNK, 0, 1, o_fetch(1, 0), "swrst_after");
    step(6'h02, 0, 1, o_decode(0), "swrst_add_decode");

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
